// File: rtl/lfsr_pattern_gen.sv
// lfsr_pattern_gen: prescaled Fibonacci LFSR LED pattern generator with step/hold/reverse/load.
// Optional feature macro: LFSR_PATTERN_GEN_LOCKUP_EN (recover from the all-zero lock-up state).
module lfsr_pattern_gen #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
    parameter logic [WIDTH-1:0] SEED         = 8'hAA,
    parameter int               PRESCALE_BIT = 20
) (
    input  logic             clk,
    input  logic             NOTRESET,
    input  logic [1:0]       mode,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             wrap
);
    logic [PRESCALE_BIT:0] r_cnt;
    logic                  r_z;
    logic [WIDTH-1:0]      r_state;
    logic                  r_tick;
    logic                  r_wrap;
    logic [PRESCALE_BIT:0] w_cnt_nx;
    logic                  w_req;
    logic [WIDTH-1:0]      w_fwd;
    logic [WIDTH-1:0]      w_rev;
    logic [WIDTH-1:0]      w_next;
    logic                  w_adv;
    logic [WIDTH-1:0]      w_load_val;
    logic                  w_fix;

    // The request uses the count as it becomes after this edge, so the advance lands on the edge
    // where the prescaler bit first changes.
    assign w_cnt_nx = r_cnt + (PRESCALE_BIT+1)'(1);
    assign w_req    = w_cnt_nx[PRESCALE_BIT] != r_z;
    assign w_fwd    = {r_state[WIDTH-2:0], ^(r_state & TAPS)};
    assign w_rev    = {r_state[0] ^ ^(r_state[WIDTH-1:1] & TAPS[WIDTH-2:0]), r_state[WIDTH-1:1]};
    assign w_next   = (mode == 2'd3) ? w_rev : w_fwd;
    assign w_adv    = ((mode == 2'd0 || mode == 2'd3) && w_req) || (mode == 2'd1 && step);
`ifdef LFSR_PATTERN_GEN_LOCKUP_EN
    assign w_load_val = (load_value == '0) ? SEED : load_value;
    assign w_fix      = r_state == '0;
`else
    assign w_load_val = load_value;
    assign w_fix      = 1'b0;
`endif

    // Free-running prescaler and its edge-detect register; unaffected by mode or load.
    always_ff @(posedge clk or posedge NOTRESET) begin
        if (NOTRESET) begin
            r_cnt <= '0;
            r_z   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nx;
            if (w_req) r_z <= w_cnt_nx[PRESCALE_BIT];
        end
    end

    // LFSR state with load > lock-up recovery > advance priority, plus registered tick/wrap.
    always_ff @(posedge clk or posedge NOTRESET) begin
        if (NOTRESET) begin
            r_state <= SEED;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_state <= w_load_val;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (w_fix) begin
            r_state <= SEED;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_adv ? w_next : r_state;
            r_tick  <= w_adv;
            r_wrap  <= w_adv && (w_next == SEED);
        end
    end

    assign led  = r_state;
    assign tick = r_tick;
    assign wrap = r_wrap;
endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// tb_lfsr_pattern_gen: scoreboard bench with a behavioural LFSR model for lfsr_pattern_gen.
module tb_lfsr_pattern_gen;
    localparam int         PB   = 2;
    localparam int         P    = 1 << PB;
    localparam logic [7:0] TAPS = 8'hB8;
    localparam logic [7:0] SEED = 8'hAA;
`ifdef LFSR_PATTERN_GEN_LOCKUP_EN
    localparam bit LOCKUP = 1'b1;
`else
    localparam bit LOCKUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       NOTRESET = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       step = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic [7:0] led;
    logic       tick;
    logic       wrap;

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  sb_q[$];
    int          m_edges;
    logic [7:0]  m_state;

    lfsr_pattern_gen #(.WIDTH(8), .TAPS(TAPS), .SEED(SEED), .PRESCALE_BIT(PB)) dut (
        .clk(clk), .NOTRESET(NOTRESET), .mode(mode), .step(step), .load(load),
        .load_value(load_value), .led(led), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] f_fwd(input logic [7:0] s);
        logic p = 1'b0;
        for (int i = 0; i < 8; i++) if (TAPS[i] && s[i]) p = ~p;
        return {s[6:0], p};
    endfunction

    // Reverse step found by searching the predecessor whose forward step yields s.
    function automatic logic [7:0] f_rev(input logic [7:0] s);
        logic [7:0] cand;
        for (int b = 0; b < 2; b++) begin
            cand = {b[0], s[7:1]};
            if (f_fwd(cand) == s) return cand;
        end
        return 8'hxx;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict the response, push it, advance to the next negedge.
    task automatic cyc(input logic [1:0] md, input logic st, input logic ld, input logic [7:0] lv);
        logic req, t, w;
        mode = md; step = st; load = ld; load_value = lv;
        m_edges++;
        req = (m_edges % P) == 0;
        t = 1'b0; w = 1'b0;
        if (ld) m_state = (LOCKUP && lv == 8'h00) ? SEED : lv;
        else if (LOCKUP && m_state == 8'h00) m_state = SEED;
        else if (((md == 2'd0 || md == 2'd3) && req) || (md == 2'd1 && st)) begin
            m_state = (md == 2'd3) ? f_rev(m_state) : f_fwd(m_state);
            t = 1'b1;
            w = m_state == SEED;
        end
        sb_q.push_back({m_state, t, w});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        NOTRESET = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        NOTRESET = 1'b0;
        m_edges = 0;
        m_state = SEED;
    endtask

    // Monitor: pops one expected response per pushed cycle and compares it to the DUT.
    initial begin
        logic [9:0] e;
        int n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n++;
                checks++;
                if ({led, tick, wrap} !== e) begin
                    errors++;
                    $display("FAIL sb #%0d: got led=%h tick=%b wrap=%b, expected led=%h tick=%b wrap=%b",
                             n, led, tick, wrap, e[9:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        int wraps;
        logic [7:0] held;
        @(negedge clk);
        chk("reset_led", led, SEED);
        chk("reset_tick", {7'd0, tick}, 8'd0);
        chk("reset_wrap", {7'd0, wrap}, 8'd0);
        do_reset();
        // Free-run forward cadence
        for (int i = 1; i <= 12; i++) begin
            cyc(2'd0, 1'b0, 1'b0, 8'h00);
            if (i == 4) chk("fr_edge4", led, 8'h55);
            if (i == 8) chk("fr_edge8", led, 8'hAB);
        end
        // Manual stepping across the full period
        do_reset();
        wraps = 0;
        for (int i = 1; i <= 255; i++) begin
            cyc(2'd1, 1'b1, 1'b0, 8'h00);
            if (i == 1) chk("step1", led, 8'h55);
            if (i == 2) chk("step2", led, 8'hAB);
            if (i < 255 && wrap) wraps++;
        end
        chk("step255_led", led, SEED);
        chk("step255_wrap", {7'd0, wrap}, 8'd1);
        chk("no_early_wrap", wraps[7:0], 8'd0);
        // Reverse back to the seed
        do_reset();
        repeat (4) cyc(2'd0, 1'b0, 1'b0, 8'h00);
        chk("rev_pre", led, 8'h55);
        repeat (4) cyc(2'd3, 1'b0, 1'b0, 8'h00);
        chk("rev_led", led, SEED);
        chk("rev_wrap", {7'd0, wrap}, 8'd1);
        // Hold, then resume
        held = led;
        repeat (64) cyc(2'd2, 1'b1, 1'b0, 8'h00);
        chk("hold_led", led, held);
        repeat (9) cyc(2'd0, 1'b0, 1'b0, 8'h00);
        // Load wins over a pending request and step
        while (((m_edges + 1) % P) != 0) cyc(2'd1, 1'b0, 1'b0, 8'h00);
        cyc(2'd1, 1'b1, 1'b1, 8'h3C);
        chk("load_led", led, 8'h3C);
        chk("load_tick", {7'd0, tick}, 8'd0);
        repeat (3) cyc(2'd0, 1'b0, 1'b0, 8'h00);
        // Zero load: recovered or locked up
        cyc(2'd1, 1'b0, 1'b1, 8'h00);
        chk("zero_load", led, LOCKUP ? SEED : 8'h00);
        repeat (4) cyc(2'd1, 1'b1, 1'b0, 8'h00);
        repeat (8) cyc(2'd3, 1'b0, 1'b0, 8'h00);
        cyc(2'd0, 1'b0, 1'b1, 8'h77);
        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cyc(2'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 15) == 0),
                8'($urandom_range(1, 255)));
        // Asynchronous reset between edges
        repeat (2) cyc(2'd1, 1'b1, 1'b0, 8'h00);
        #2 NOTRESET = 1'b1;
        #1;
        chk("async_led", led, SEED);
        chk("async_tick", {7'd0, tick}, 8'd0);
        chk("async_wrap", {7'd0, wrap}, 8'd0);
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            cyc(2'd0, 1'b0, 1'b0, 8'h00);
            if (i == 3) chk("post_rst_idle", led, SEED);
            if (i == 4) chk("post_rst_edge4", led, 8'h55);
        end
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_pattern_gen.md
# lfsr_pattern_gen

Parametrised Fibonacci LFSR pattern generator that drives a bank of LEDs from a prescaled free-running counter. It replaces the fixed 8-bit, fixed-tap, fixed-rate blinker with configurable width, taps, seed and rate. It adds manual stepping, hold, reverse stepping, seed load and a period-wrap indication. It sits between the board clock/reset and the LED pins, or feeds any block that needs a slow pseudo-random pattern.

## Interface
- WIDTH, 8: LFSR and LED width; legal range 2..32.
- TAPS, 8'hB8: feedback mask; bit i set means state[i] feeds the XOR. TAPS[WIDTH-1] must be 1.
- SEED, 8'hAA: reset and wrap-reference state; must be non-zero.
- PRESCALE_BIT, 20: prescaler bit whose every edge requests an advance; range 0..31.

- clk  in  1  clock.
- NOTRESET  in  1  asynchronous, active-high reset (high = reset).
- mode  in  2  0 = free-run forward, 1 = manual step, 2 = hold, 3 = free-run reverse.
- step  in  1  in mode 1, advance forward once per cycle sampled high.
- load  in  1  load load_value into state this cycle.
- load_value  in  WIDTH  value for load.
- led  out  WIDTH  registered LFSR state.
- tick  out  1  registered; high for the one cycle in which led shows a newly advanced value.
- wrap  out  1  registered; high with tick when the advanced value equals SEED.

## Operation
- Reset values: led = SEED, tick = 0, wrap = 0, prescaler cnt = 0, edge register z = 0.
- Prescaler:
  - cnt is PRESCALE_BIT+1 bits wide and increments every cycle in all modes, wrapping modulo 2^(PRESCALE_BIT+1).
  - req = (cnt[PRESCALE_BIT] != z). When req is high, z <= cnt[PRESCALE_BIT].
- Forward step: fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}.
- Reverse step: next = {state[0] ^ XOR-reduce(state[WIDTH-1:1] & TAPS[WIDTH-2:0]), state[WIDTH-1:1]}. This is the exact inverse of the forward step.
- Per-cycle priority:
  1. load: state <= load_value. tick = 0, wrap = 0. Any req in this cycle is consumed and does not advance.
  2. mode 0 and req: forward step.
  3. mode 3 and req: reverse step.
  4. mode 1 and step: forward step. req is ignored.
  5. mode 2: no change. req is still consumed.
- tick = 1 exactly when case 2, 3 or 4 fires. wrap = tick and (next == SEED).
- A mode change takes effect in the same cycle it is presented. The prescaler is never reset by mode changes or load.
- Arithmetic: cnt wraps silently. The LFSR has no width growth.

## Timing
- Free-run: the first advance happens on the 2^PRESCALE_BIT-th rising edge after reset deasserts (when cnt first shows bit PRESCALE_BIT set). Later advances follow every 2^PRESCALE_BIT edges.
- Manual step: 1-cycle latency; step high at edge N makes led update and tick go high after edge N. Step held high advances once per cycle.
- load: led = load_value after the same edge.
- Reset asserted mid-operation: all registers return to reset values immediately, without waiting for a clock edge.

## Configuration
- LFSR_PATTERN_GEN_LOCKUP_EN defined:
  - A load of all-zero writes SEED instead.
  - If state is ever observed all-zero, it is forced to SEED on the next edge with tick = 0.
- LFSR_PATTERN_GEN_LOCKUP_EN undefined:
  - A zero load is accepted and the LFSR stays at zero in every mode (documented lock-up).
  - wrap never fires while in lock-up.

## Test plan
- Default parameters, PRESCALE_BIT = 2, mode 0 after reset -> led = 0xAA; tick on edge 4 with led = 0x55; tick on edge 8 with led = 0xAB; no tick in between.
- mode 1, step pulses from reset -> 0x55, then 0xAB, with tick each cycle. After 255 steps led = 0xAA and wrap = 1. wrap is 0 for steps 1..254.
- Reach led = 0x55, then mode 3 at PRESCALE_BIT = 2 -> next tick gives led = 0xAA with wrap = 1.
- mode 2 for 64 cycles -> led constant, tick = 0. Returning to mode 0 resumes at the original prescaler cadence.
- load with load_value = 0x3C while req and step are both active -> led = 0x3C, tick = 0. A zero load gives 0xAA with LFSR_PATTERN_GEN_LOCKUP_EN and 0x00 (stuck) without it.
- Assert NOTRESET mid-run between edges -> led = 0xAA and tick = 0 immediately. The first advance after release follows the same reset-relative timing as the first scenario.
